csa_divider_16bit: RTL

- Sequential unsigned integer divider: WIDTH-bit dividend / WIDTH-bit divisor -> quotient, remainder.
- Inverse datapath companion to the 16-bit conditional-sum adder/multiplier path.
- Restoring algorithm, one quotient bit per clock, start/busy/done handshake.
- Sits beside the multiplier so the arithmetic unit offers both product and quotient.

---
 rtl/csa_divider_16bit_if.sv | 30 +++
 rtl/csa_divider_16bit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/csa_divider_16bit_if.sv
`default_nettype none
// ============================================================================
// Module      : csa_divider_16bit_if
// Description : start/busy/done handshake and operand/result bus for the
//               sequential unsigned divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface csa_divider_16bit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/csa_divider_16bit.sv
`default_nettype none
// ============================================================================
// Module      : csa_divider_16bit
// Description : Restoring unsigned divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_divider_16bit #(
    parameter int WIDTH = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    csa_divider_16bit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_prem;
    logic [WIDTH-1:0] r_dshreg;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_busy;
    logic             w_done;
    logic             w_accept;
    logic             w_zero_div;
    logic             w_last;
    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_prem_nxt;
    logic [WIDTH-1:0] w_dsh_nxt;

    assign w_accept   = (r_state == S_IDLE) && bus.start;
    assign w_zero_div = (bus.divisor == '0);
    assign w_last     = (r_count == CNT_W'(1));

    // The stored remainder is always below the divisor, so WIDTH bits hold it;
    // only the shifted trial value needs the extra bit.
    assign w_shift_rem = {r_prem, r_dshreg[WIDTH-1]};
    assign w_trial     = w_shift_rem - {1'b0, r_divisor};
    assign w_qbit      = ~w_trial[WIDTH];
    assign w_prem_nxt  = w_qbit ? w_trial[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
    assign w_dsh_nxt   = {r_dshreg[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_zero_div ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_prem      <= '0;
            r_dshreg    <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_prem    <= '0;
            r_dshreg  <= bus.dividend;
            r_divisor <= bus.divisor;
            if (w_zero_div) begin
                r_count     <= '0;
                r_quotient  <= '1;
                r_remainder <= bus.dividend;
                r_dbz       <= 1'b1;
            end else begin
                r_count <= CNT_W'(WIDTH);
            end
        end else if (r_state == S_RUN) begin
            r_prem   <= w_prem_nxt;
            r_dshreg <= w_dsh_nxt;
            r_count  <= r_count - CNT_W'(1);
            if (w_last) begin
                r_quotient  <= w_dsh_nxt;
                r_remainder <= w_prem_nxt;
                r_dbz       <= 1'b0;
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule
`default_nettype wire
